// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch sequencer: the FSM state
// encoding, the sequential PC step and the default reset PC.
package fetch_pkg;

    // Fetch FSM states.
    // IDLE: post-reset bubble, REQ: request presented to memory,
    // WAIT: one request outstanding, HOLD: instruction presented to decode,
    // HALT: fetching stopped until reset.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_t;

    // Instructions are 32-bit words, so sequential fetch advances by 4 bytes.
    localparam logic [31:0] PC_STEP = 32'd4;

    // PC loaded on reset unless the instance overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the program counter and walks the instruction memory through a
// request/response handshake, presenting each fetched word to the datapath
// with a valid/ack handshake. Applies branch/jump redirects and halt.
//
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   imem_req/addr     : fetch request and address (address always equals pc)
//   imem_ready        : memory accepts the request this cycle
//   imem_rvalid/rdata : one-cycle read response and instruction word
//   instr_valid       : Instruction_Code/instr_pc hold a live instruction
//   Instruction_Code  : fetched instruction word
//   instr_pc          : PC of Instruction_Code
//   instr_ack         : datapath consumes the instruction (only while valid)
//   redirect_valid/pc : taken branch/jump and its target (low 2 bits ignored)
//   halt              : stop fetching until reset
//   halted            : sequencer is in HALT
//   fetch_count       : number of acknowledged instructions, wrapping
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       Instruction_Code,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ack,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              squash, squash_n;
    logic              halt_pend, halt_pend_n;
    logic              instr_valid_n;
    logic [31:0]       code_n;
    logic [ADDR_W-1:0] instr_pc_n;
    logic [31:0]       fetch_count_n;
    logic [ADDR_W-1:0] redirect_aligned;

    // Masking (rather than slicing) keeps every bit of redirect_pc in use.
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    assign imem_addr = pc;
    assign imem_req  = (state == ST_REQ);
    assign halted    = (state == ST_HALT);

    // State and datapath registers; everything is computed combinationally
    // below and simply captured here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            pc               <= RESET_PC;
            squash           <= 1'b0;
            halt_pend        <= 1'b0;
            instr_valid      <= 1'b0;
            Instruction_Code <= 32'd0;
            instr_pc         <= '0;
            fetch_count      <= 32'd0;
        end else begin
            state            <= state_n;
            pc               <= pc_n;
            squash           <= squash_n;
            halt_pend        <= halt_pend_n;
            instr_valid      <= instr_valid_n;
            Instruction_Code <= code_n;
            instr_pc         <= instr_pc_n;
            fetch_count      <= fetch_count_n;
        end
    end

    // Next-state, next-PC and instruction-register logic. A redirect always
    // wins over the sequential increment. Halt only changes where the FSM
    // goes; the PC still follows the normal rules in the cycle halt is seen.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        squash_n      = squash;
        halt_pend_n   = halt_pend;
        instr_valid_n = instr_valid;
        code_n        = Instruction_Code;
        instr_pc_n    = instr_pc;
        fetch_count_n = fetch_count;

        case (state)
            ST_IDLE: begin
                if (redirect_valid) pc_n = redirect_aligned;
                state_n = halt ? ST_HALT : ST_REQ;
            end

            ST_REQ: begin
                if (redirect_valid) pc_n = redirect_aligned;
                if (halt) begin
                    state_n = ST_HALT;
                end else if (imem_ready) begin
                    // Memory latched the old pc; if the target changed in the
                    // same cycle, the returning word belongs to a dead path.
                    state_n  = ST_WAIT;
                    squash_n = redirect_valid;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_n     = redirect_aligned;
                    squash_n = 1'b1;
                end
                if (halt) halt_pend_n = 1'b1;
                if (imem_rvalid) begin
                    squash_n    = 1'b0;
                    halt_pend_n = 1'b0;
                    if (halt_pend || halt) begin
                        state_n = ST_HALT;
                    end else if (squash || redirect_valid) begin
                        state_n = ST_REQ;
                    end else begin
                        instr_valid_n = 1'b1;
                        code_n        = imem_rdata;
                        instr_pc_n    = pc;
                        state_n       = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (instr_ack) begin
                    instr_valid_n = 1'b0;
                    fetch_count_n = fetch_count + 32'd1;
                    pc_n          = redirect_valid ? redirect_aligned
                                                   : pc + ADDR_W'(PC_STEP);
                    state_n       = ST_REQ;
                end else if (redirect_valid) begin
                    instr_valid_n = 1'b0;
                    pc_n          = redirect_aligned;
                    state_n       = ST_REQ;
                end
                if (halt) begin
                    instr_valid_n = 1'b0;
                    state_n       = ST_HALT;
                end
            end

            ST_HALT: begin
                instr_valid_n = 1'b0;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer: a behavioural memory, a
// transaction-level model of the fetch rules, directed scenarios with
// literal expectations, then a randomized run compared every cycle.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] Instruction_Code;
    logic [31:0] instr_pc;
    logic        instr_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    // Model of the fetch rules, expressed as facts about the fetch process:
    // waiting to request, request in flight, instruction on offer, halted.
    bit          m_req, m_fly, m_hold, m_halt, m_stale, m_hpend;
    logic [31:0] m_pc, m_cnt, m_word, m_wpc;

    // Memory model: at most one pending response with a countdown.
    bit          mem_pending;
    int          mem_wait;
    logic [31:0] mem_data;
    int          lat_lo = 0;
    int          lat_hi = 0;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .instr_valid      (instr_valid),
        .Instruction_Code (Instruction_Code),
        .instr_pc         (instr_pc),
        .instr_ack        (instr_ack),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .halt             (halt),
        .halted           (halted),
        .fetch_count      (fetch_count)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of instruction memory; address 0 holds a known word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2010_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_req = 0; m_fly = 0; m_hold = 0; m_halt = 0; m_stale = 0; m_hpend = 0;
        m_pc = 32'd0; m_cnt = 32'd0; m_word = 32'd0; m_wpc = 32'd0;
        mem_pending = 0; mem_wait = 0; mem_data = 32'd0;
    endtask

    // Advance the model by one clock using the inputs that were just sampled.
    task automatic modelStep();
        logic [31:0] tgt;
        logic [31:0] old_pc;
        bit          r, h, drop, stop;
        tgt    = {redirect_pc[31:2], 2'b00};
        r      = redirect_valid;
        h      = halt;
        old_pc = m_pc;
        drop   = m_stale || r;
        stop   = m_hpend || h;
        if (m_halt) return;
        if (!(m_req || m_fly || m_hold)) begin
            if (r) m_pc = tgt;
            if (h) m_halt = 1; else m_req = 1;
        end else if (m_req) begin
            if (r) m_pc = tgt;
            if (h) begin
                m_req = 0; m_halt = 1;
            end else if (imem_ready) begin
                m_req = 0; m_fly = 1; m_stale = r;
            end
        end else if (m_fly) begin
            if (r) m_pc = tgt;
            if (imem_rvalid) begin
                m_fly = 0; m_stale = 0; m_hpend = 0;
                if (stop) m_halt = 1;
                else if (drop) m_req = 1;
                else begin
                    m_hold = 1; m_word = imem_rdata; m_wpc = old_pc;
                end
            end else begin
                if (r) m_stale = 1;
                if (h) m_hpend = 1;
            end
        end else begin
            if (instr_ack) begin
                m_cnt = m_cnt + 1;
                m_pc  = r ? tgt : m_pc + 32'd4;
            end else if (r) begin
                m_pc = tgt;
            end
            if (h) begin
                m_hold = 0; m_halt = 1;
            end else if (instr_ack || r) begin
                m_hold = 0; m_req = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, let the clock edge happen, then update the
    // model and the memory with what was sampled at that edge.
    task automatic applyStimulus(input logic rdy, input logic ack, input logic r,
                                 input logic [31:0] tgt, input logic h);
        bit          acc;
        logic [31:0] acc_addr;
        if (mem_pending && mem_wait == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem_data;
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
        end
        imem_ready = rdy; instr_ack = ack; redirect_valid = r; redirect_pc = tgt; halt = h;
        @(posedge clk);
        #1;
        acc      = m_req && rdy;
        acc_addr = m_pc;
        modelStep();
        if (imem_rvalid) mem_pending = 0;
        else if (mem_pending) mem_wait--;
        if (acc) begin
            mem_pending = 1;
            mem_wait    = $urandom_range(lat_hi, lat_lo);
            mem_data    = mem_word(acc_addr);
        end
    endtask

    task automatic assertReset();
        reset = 1'b1;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0; instr_ack = 0;
        redirect_valid = 0; redirect_pc = 0; halt = 0;
        modelReset();
        check_en = 1;
    endtask

    task automatic releaseReset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"}, imem_req, 0);
        checkOutput({tag, "_addr"}, imem_addr, 0);
        checkOutput({tag, "_valid"}, instr_valid, 0);
        checkOutput({tag, "_code"}, Instruction_Code, 0);
        checkOutput({tag, "_ipc"}, instr_pc, 0);
        checkOutput({tag, "_halted"}, halted, 0);
        checkOutput({tag, "_count"}, fetch_count, 0);
    endtask

    // Compare process: every cycle, mid-period, the DUT must match the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("m_imem_req", imem_req, m_req);
            checkOutput("m_imem_addr", imem_addr, m_pc);
            checkOutput("m_instr_valid", instr_valid, m_hold);
            checkOutput("m_halted", halted, m_halt);
            checkOutput("m_fetch_count", fetch_count, m_cnt);
            if (m_hold) begin
                checkOutput("m_instr_code", Instruction_Code, m_word);
                checkOutput("m_instr_pc", instr_pc, m_wpc);
            end
        end
    end

    // Directed scenarios with hand-computed values, then a randomized run.
    initial begin
        int halt_cycles;
        reset = 1'b0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0; instr_ack = 0;
        redirect_valid = 0; redirect_pc = 0; halt = 0;
        #2;
        assertReset();
        releaseReset();
        checkResetValues("rst");

        // Zero-wait first fetch: REQ at cycle 1, instruction at cycle 3.
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("c1_req", imem_req, 1);
        checkOutput("c1_addr", imem_addr, 32'h0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("c2_req", imem_req, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("c3_valid", instr_valid, 1);
        checkOutput("c3_ipc", instr_pc, 32'h0);
        checkOutput("c3_code", Instruction_Code, 32'h2010_0005);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("c4_addr", imem_addr, 32'h4);
        checkOutput("c4_count", fetch_count, 1);
        checkOutput("c4_valid", instr_valid, 0);

        // Fetch 0x4, then memory stalls the request for 0x8.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("stall_req", imem_req, 1);
            checkOutput("stall_addr", imem_addr, 32'h8);
            checkOutput("stall_valid", instr_valid, 0);
        end
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stall_ipc", instr_pc, 32'h8);
        applyStimulus(0, 1, 0, 0, 0);

        // Redirect to 0x40 while 0xC is outstanding.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h40, 0);
        checkOutput("sq_addr", imem_addr, 32'h40);
        checkOutput("sq_valid", instr_valid, 0);
        checkOutput("sq_count", fetch_count, 3);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sq_ipc", instr_pc, 32'h40);
        checkOutput("sq_count2", fetch_count, 3);
        applyStimulus(0, 1, 0, 0, 0);

        // Ack plus redirect in HOLD, then unaligned redirect targets.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h100, 0);
        checkOutput("ackred_addr", imem_addr, 32'h100);
        checkOutput("ackred_count", fetch_count, 5);
        applyStimulus(0, 0, 1, 32'h10B, 0);
        checkOutput("align_addr1", imem_addr, 32'h108);
        applyStimulus(0, 0, 1, 32'h103, 0);
        checkOutput("align_addr2", imem_addr, 32'h100);

        // PC wrap at the top of the address space.
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wrap_addr", imem_addr, 32'h0);
        checkOutput("wrap_count", fetch_count, 6);

        // Halt while a slow response is outstanding.
        lat_lo = 2; lat_hi = 2;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("hw_halted0", halted, 0);
        checkOutput("hw_req0", imem_req, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("hw_halted1", halted, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("hw_halted2", halted, 1);
        checkOutput("hw_valid", instr_valid, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 0);
            checkOutput("halt_req", imem_req, 0);
            checkOutput("halt_flag", halted, 1);
            checkOutput("halt_count", fetch_count, 6);
        end

        // Reset in HALT takes effect without a clock edge.
        assertReset();
        #1;
        checkResetValues("rst_halt");
        releaseReset();

        // Randomized traffic, reset whenever the model has sat halted a while.
        lat_lo = 0; lat_hi = 2;
        halt_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 1023));
            applyStimulus($urandom_range(0, 9) < 6, 1'($urandom), $urandom_range(0, 9) == 0,
                          tgt, $urandom_range(0, 299) == 0);
            if (m_halt) halt_cycles++;
            if (halt_cycles > 8 || (i % 700) == 699) begin
                halt_cycles = 0;
                assertReset();
                releaseReset();
            end
        end

        check_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch controller that owns the program counter and sequences the instruction memory through a request/response handshake. It presents each fetched word to the decode/datapath with a valid/ack handshake, and applies branch/jump redirects and halt. It sits between the control unit (redirect, halt) and the instruction memory (imem_*). It replaces the free-running PC register feeding the IFU.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
ADDR_W, 32, PC/address width.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address, equal to current PC
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid, one cycle pulse
imem_rdata  input  32  instruction word from memory
instr_valid  output  1  Instruction_Code/instr_pc hold a live instruction
Instruction_Code  output  32  fetched instruction
instr_pc  output  ADDR_W  PC of Instruction_Code
instr_ack  input  1  datapath consumes instruction (effective only when instr_valid=1)
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  ADDR_W  target; bits [1:0] forced to 0 internally
halt  input  1  stop fetching permanently until reset
halted  output  1  block is in HALT
fetch_count  output  32  number of instructions acked, wraps at 2^32

Behaviour:
- Reset (asynchronous, any state): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, Instruction_Code=0, instr_pc=0, squash=0, halted=0, fetch_count=0.
- imem_addr=pc at all times. Memory samples the address only in a cycle with imem_req&&imem_ready. A response arrives at least one cycle later; only one request is outstanding.
- IDLE: one bubble cycle, then go to REQ.
- REQ: imem_req=1. Redirect updates pc (the address may change before acceptance). On imem_ready, go to WAIT and drop imem_req the next cycle.
- WAIT: imem_req=0. A redirect sets pc=redirect_pc and squash=1.
  - On imem_rvalid with squash=1, or with a redirect in the same cycle: discard data, clear squash, go to REQ.
  - On imem_rvalid otherwise: register Instruction_Code=imem_rdata, instr_pc=pc, instr_valid=1, go to HOLD.
- HOLD: outputs stay stable until consumed.
  - instr_ack: instr_valid=0, fetch_count+1, pc=redirect_valid?redirect_pc:pc+4, go to REQ.
  - redirect without ack: instruction dropped (count unchanged), pc=redirect_pc, go to REQ.
- pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC goes to 0).
- Redirect always beats sequential increment.
- HALT entry:
  - halt in IDLE/REQ/HOLD goes to HALT next cycle.
  - halt in WAIT sets a pending flag; the outstanding response is absorbed and discarded on imem_rvalid, then go to HALT.
  - halt in HOLD together with instr_ack still counts the ack.
- HALT: imem_req=0, instr_valid=0, halted=1. Redirect and ack are ignored. Only reset exits.
- Zero-wait memory (ready=1, rvalid one cycle after accept, ack immediate): reset deasserts at cycle 0, REQ at cycle 1, instr_valid at cycle 3. Steady state is one instruction per 3 cycles.

Decomposition:
- Shared package fetch_pkg: state encoding (IDLE, REQ, WAIT, HOLD, HALT), PC_STEP=4, default RESET_PC.
- No sub-module needed. Next-PC selection stays an inline always block; a separate next_pc_mux adds nothing.

Test Plan:
- Reset released; memory returns 32'h2010_0005 at 0x0; ack immediately -> instr_valid at cycle 3 with instr_pc=0. Next request imem_addr=0x4; fetch_count=1.
- imem_ready held low 4 cycles in REQ -> imem_req stays 1, addr stable at 0x8, no instr_valid until the response.
- Redirect to 0x40 during WAIT for 0xC -> the 0xC response is discarded. Next request is 0x40, instr_pc=0x40, and the count does not advance for 0xC.
- HOLD with ack and redirect to 0x100 in the same cycle -> fetch_count+1, next imem_addr=0x100 (not pc+4). Redirect 0x103 -> fetch from 0x100.
- PC=32'hFFFF_FFFC acked -> next imem_addr=0.
- Halt in WAIT -> response absorbed, halted=1 next cycle, imem_req stays 0 for 20 cycles. Reset mid-HALT -> IDLE, pc=RESET_PC, outputs return to reset values immediately.
